vram_char_editor: RTL



---
 rtl/vram_char_editor_pkg.sv | 26 ++
 rtl/vram_char_editor_if.sv | 25 ++
 rtl/vram_char_editor_button_debouncer.sv | 103 ++++++++++
 rtl/vram_char_editor.sv | 86 ++++++++
 4 files changed

// File: rtl/vram_char_editor_pkg.sv
// Shared constants, widths and types for the VGA character editor path.
package vram_editor_pkg;

  localparam int unsigned NUM_REGIONS     = 4;
  localparam int unsigned NUM_LETTERS     = 26;
  localparam int unsigned DEBOUNCE_CYCLES = 500000;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned RW = idx_width(NUM_REGIONS);
  localparam int unsigned LW = idx_width(NUM_LETTERS);

  typedef logic [RW-1:0] region_t;
  typedef logic [LW-1:0] letter_t;

  typedef enum logic [1:0] {
    RELEASED,
    CONFIRM_PRESS,
    PRESSED,
    CONFIRM_RELEASE
  } debounce_state_t;

endpackage

// File: rtl/vram_char_editor_if.sv
// Letter-table bus between the editor (master) and the VRAM reader/mirror (slave).
interface vram_char_editor_if #(
  parameter int unsigned NUM_REGIONS = vram_editor_pkg::NUM_REGIONS,
  parameter int unsigned NUM_LETTERS = vram_editor_pkg::NUM_LETTERS
);
  localparam int unsigned RW = vram_editor_pkg::idx_width(NUM_REGIONS);
  localparam int unsigned LW = vram_editor_pkg::idx_width(NUM_LETTERS);

  logic [RW-1:0] RdRegion;
  logic [LW-1:0] RdLetter;
  logic [RW-1:0] SelRegion;
  logic          WrStrobe;
  logic [RW-1:0] WrRegion;
  logic [LW-1:0] WrLetter;

  modport master (
    input  RdRegion,
    output RdLetter, SelRegion, WrStrobe, WrRegion, WrLetter
  );

  modport slave (
    output RdRegion,
    input  RdLetter, SelRegion, WrStrobe, WrRegion, WrLetter
  );
endinterface

// File: rtl/vram_char_editor_button_debouncer.sv
// Two-flop synchronizer plus confirm-counting debounce FSM; one pulse per accepted press.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = vram_editor_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic BtnRaw,
  output logic Pressed,
  output logic PressPulse
);
  import vram_editor_pkg::*;

  localparam int unsigned   CW        = idx_width(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CntLast   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          IdleLevel = (BTN_ACTIVE_LOW != 0);

  logic            sync1_q, sync2_q, sample;
  debounce_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  assign sample = sync2_q ^ IdleLevel;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= IdleLevel;
      sync2_q <= IdleLevel;
      state_q <= RELEASED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= BtnRaw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Counter holds the number of consecutive samples that disagree with the accepted level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (sample) begin
          if (CntLast == '0) begin
            state_d = PRESSED;
            pulse_d = 1'b1;
          end else begin
            state_d = CONFIRM_PRESS;
            cnt_d   = CW'(1);
          end
        end
      end
      CONFIRM_PRESS: begin
        if (!sample) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!sample) begin
          if (CntLast == '0) begin
            state_d = RELEASED;
          end else begin
            state_d = CONFIRM_RELEASE;
            cnt_d   = CW'(1);
          end
        end
      end
      CONFIRM_RELEASE: begin
        if (sample) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    Pressed    = (state_q == PRESSED) || (state_q == CONFIRM_RELEASE);
    PressPulse = pulse_q;
  end

endmodule

// File: rtl/vram_char_editor.sv
// Button-driven per-region letter table with registered read port and write mirror strobe.
module vram_char_editor #(
  parameter int unsigned NUM_REGIONS     = vram_editor_pkg::NUM_REGIONS,
  parameter int unsigned NUM_LETTERS     = vram_editor_pkg::NUM_LETTERS,
  parameter int unsigned DEBOUNCE_CYCLES = vram_editor_pkg::DEBOUNCE_CYCLES,
  parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Region,
  input  logic                  Letra,
  vram_char_editor_if.master    bus
);
  import vram_editor_pkg::*;

  localparam int unsigned   RW          = idx_width(NUM_REGIONS);
  localparam int unsigned   LW          = idx_width(NUM_LETTERS);
  localparam logic [RW-1:0] LastRegion  = RW'(NUM_REGIONS - 1);
  localparam logic [LW-1:0] LastLetter  = LW'(NUM_LETTERS - 1);
  localparam logic [RW:0]   RegionCount = (RW + 1)'(NUM_REGIONS);

  logic          region_press, letra_press;
  logic [LW-1:0] table_q [NUM_REGIONS];
  logic [RW-1:0] sel_q, wr_region_q;
  logic [LW-1:0] rd_letter_q, wr_letter_q;
  logic          wr_strobe_q;
  logic [LW-1:0] cur_letter, next_letter;
  logic          rd_valid;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_region_db (
    .Clk       (Clk),
    .Reset     (Reset),
    .BtnRaw    (Region),
    .Pressed   (),
    .PressPulse(region_press)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_letra_db (
    .Clk       (Clk),
    .Reset     (Reset),
    .BtnRaw    (Letra),
    .Pressed   (),
    .PressPulse(letra_press)
  );

  always_comb begin
    cur_letter  = table_q[sel_q];
    next_letter = (cur_letter == LastLetter) ? '0 : cur_letter + 1'b1;
    // Non-power-of-two region counts leave unused read addresses; those read as 0.
    rd_valid    = {1'b0, bus.RdRegion} < RegionCount;
  end

  // Read samples the pre-edge table, so a same-edge write shows up one cycle later.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NUM_REGIONS; i++) table_q[i] <= '0;
      sel_q       <= '0;
      rd_letter_q <= '0;
      wr_strobe_q <= 1'b0;
      wr_region_q <= '0;
      wr_letter_q <= '0;
    end else begin
      rd_letter_q <= rd_valid ? table_q[bus.RdRegion] : '0;
      wr_strobe_q <= letra_press;
      if (letra_press) begin
        table_q[sel_q] <= next_letter;
        wr_region_q    <= sel_q;
        wr_letter_q    <= next_letter;
      end
      if (region_press) sel_q <= (sel_q == LastRegion) ? '0 : sel_q + 1'b1;
    end
  end

  assign bus.RdLetter  = rd_letter_q;
  assign bus.SelRegion = sel_q;
  assign bus.WrStrobe  = wr_strobe_q;
  assign bus.WrRegion  = wr_region_q;
  assign bus.WrLetter  = wr_letter_q;

endmodule
